vga_pixel_scan_gen: RTL and testbench

//  Source end of the pixelX/pixelY drawing bus: scans the 640x480 raster, drives pixel coordinates
//  to every drawing/background block, and generates hsync, vsync and the visible-area flag for the
//  VGA DAC. Also flags frame boundaries for game logic. Sits between the pixel clock and all drawers.

---
 rtl/vga_pixel_scan_gen.sv | 141 ++++++++++++++
 tb/tb_vga_pixel_scan_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/vga_pixel_scan_gen.sv
// VGA raster scanner: pixel coordinates, sync, visible flag and frame markers.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync/visible by DRAW_LATENCY pixel enables.
module vga_pixel_scan_gen #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter bit          SYNC_POL     = 1'b0,
  parameter int unsigned DRAW_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixelCE,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        visible,
  output logic        hsync,
  output logic        vsync,
  output logic        startOfFrame,
  output logic [7:0]  frameCount
);

  localparam logic [10:0] HFpStart   = 11'(H_ACTIVE);
  localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HBpStart   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HLast      = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] VFpStart   = 11'(V_ACTIVE);
  localparam logic [10:0] VSyncStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VBpStart   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VLast      = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {StAct, StFp, StSync, StBp} phase_e;

  phase_e      h_q, h_d, v_q, v_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [7:0]  fc_q, fc_d;
  logic        sof_q, sof_d;
  logic        hs_q, vs_q, vis_q;
  logic        line_end, frame_end;

  always_comb begin
    line_end  = (x_q == HLast);
    frame_end = line_end && (y_q == VLast);
    x_d   = x_q;
    y_d   = y_q;
    h_d   = h_q;
    v_d   = v_q;
    fc_d  = fc_q;
    sof_d = 1'b0;
    if (pixelCE) begin
      x_d = line_end ? 11'd0 : x_q + 11'd1;
      if (line_end) y_d = (y_q == VLast) ? 11'd0 : y_q + 11'd1;
      if (frame_end) begin
        sof_d = 1'b1;
        fc_d  = fc_q + 8'd1;
      end
      // Phase transitions look at the next count so sync/visible line up with it.
      case (h_q)
        StAct:  if (x_d == HFpStart)   h_d = StFp;
        StFp:   if (x_d == HSyncStart) h_d = StSync;
        StSync: if (x_d == HBpStart)   h_d = StBp;
        StBp:   if (x_d == 11'd0)      h_d = StAct;
      endcase
      if (line_end) begin
        case (v_q)
          StAct:  if (y_d == VFpStart)   v_d = StFp;
          StFp:   if (y_d == VSyncStart) v_d = StSync;
          StSync: if (y_d == VBpStart)   v_d = StBp;
          StBp:   if (y_d == 11'd0)      v_d = StAct;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      h_q   <= StAct;
      v_q   <= StAct;
      fc_q  <= '0;
      sof_q <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      vis_q <= 1'b1;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fc_q  <= fc_d;
      sof_q <= sof_d;
      hs_q  <= (h_d == StSync) ? SYNC_POL : ~SYNC_POL;
      vs_q  <= (v_d == StSync) ? SYNC_POL : ~SYNC_POL;
      vis_q <= (h_d == StAct) && (v_d == StAct);
    end
  end

  always_ff @(posedge clk) begin
    assert (DRAW_LATENCY inside {[1:4]});
  end

  assign pixelX       = x_q;
  assign pixelY       = y_q;
  assign startOfFrame = sof_q;
  assign frameCount   = fc_q;

`ifdef VGA_SYNC_ALIGN_EN
  logic [DRAW_LATENCY-1:0] hs_pipe_q, vs_pipe_q, vis_pipe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_pipe_q  <= {DRAW_LATENCY{~SYNC_POL}};
      vs_pipe_q  <= {DRAW_LATENCY{~SYNC_POL}};
      vis_pipe_q <= {DRAW_LATENCY{1'b1}};
    end else if (pixelCE) begin
      hs_pipe_q[0]  <= hs_q;
      vs_pipe_q[0]  <= vs_q;
      vis_pipe_q[0] <= vis_q;
      for (int i = 1; i < int'(DRAW_LATENCY); i++) begin
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
        vis_pipe_q[i] <= vis_pipe_q[i-1];
      end
    end
  end

  assign hsync   = hs_pipe_q[DRAW_LATENCY-1];
  assign vsync   = vs_pipe_q[DRAW_LATENCY-1];
  assign visible = vis_pipe_q[DRAW_LATENCY-1];
`else
  assign hsync   = hs_q;
  assign vsync   = vs_q;
  assign visible = vis_q;
`endif

endmodule

// File: tb/tb_vga_pixel_scan_gen.sv
// Self-checking bench for vga_pixel_scan_gen on a shrunken raster (15x8) with random pixelCE.
module tb_vga_pixel_scan_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam bit POL = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixelCE = 1'b1;
  logic [10:0] pixelX, pixelY;
  logic        visible, hsync, vsync, startOfFrame;
  logic [7:0]  frameCount;

  vga_pixel_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .DRAW_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .pixelCE(pixelCE),
    .pixelX(pixelX), .pixelY(pixelY), .visible(visible),
    .hsync(hsync), .vsync(vsync), .startOfFrame(startOfFrame),
    .frameCount(frameCount)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;

  // Reference state: position, frame count, pulse, and (when aligned) one delayed sync sample.
  int mx = 0, my = 0, mfc = 0;
  bit msof = 0;
  bit d_hs = !POL, d_vs = !POL, d_vis = 1'b1;

  function automatic bit ref_hs(int x);
    return (x >= HA + HF && x < HA + HF + HS) ? POL : !POL;
  endfunction
  function automatic bit ref_vs(int y);
    return (y >= VA + VF && y < VA + VF + VS) ? POL : !POL;
  endfunction
  function automatic bit ref_vis(int x, int y);
    return (x < HA) && (y < VA);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d (x=%0d y=%0d)", tag, obs, exp, mx, my);
  endtask

  task automatic step(input bit ce, input bit rst);
    bit e_hs, e_vs, e_vis;
    pixelCE = ce;
    reset   = rst;
    @(posedge clk);
    if (rst) begin
      mx = 0; my = 0; mfc = 0; msof = 0;
      d_hs = !POL; d_vs = !POL; d_vis = 1'b1;
    end else if (ce) begin
      d_hs = ref_hs(mx); d_vs = ref_vs(my); d_vis = ref_vis(mx, my);
      msof = 0;
      if (mx == HT - 1) begin
        mx = 0;
        if (my == VT - 1) begin
          my = 0; msof = 1; mfc = (mfc + 1) % 256;
        end else my++;
      end else mx++;
    end else begin
      msof = 0;
    end
`ifdef VGA_SYNC_ALIGN_EN
    e_hs = d_hs; e_vs = d_vs; e_vis = d_vis;
`else
    e_hs = ref_hs(mx); e_vs = ref_vs(my); e_vis = ref_vis(mx, my);
`endif
    #1;
    check("pixelX", 32'(pixelX), 32'(mx));
    check("pixelY", 32'(pixelY), 32'(my));
    check("visible", 32'(visible), 32'(e_vis));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("startOfFrame", 32'(startOfFrame), 32'(msof));
    check("frameCount", 32'(frameCount), 32'(mfc));
  endtask

  initial begin
    int cnt, sof_seen, limit;

    // Reset held 3 clocks with pixelCE high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("reset_hsync_idle", 32'(hsync), 32'(!POL));
    check("reset_visible", 32'(visible), 32'd1);

    // Free run: frame period between startOfFrame pulses.
    cnt = 0; sof_seen = 0;
    while (sof_seen == 0 && cnt < 2 * HT * VT) begin
      step(1'b1, 1'b0); cnt++;
      if (startOfFrame) sof_seen = 1;
    end
    check("first_sof_clk", 32'(cnt), 32'(HT * VT));
    check("first_sof_frameCount", 32'(frameCount), 32'd1);
    cnt = 0; sof_seen = 0;
    while (sof_seen == 0 && cnt < 2 * HT * VT) begin
      step(1'b1, 1'b0); cnt++;
      if (startOfFrame) sof_seen = 1;
    end
    check("frame_period", 32'(cnt), 32'(HT * VT));

    // Alternating pixelCE: hsync low time doubles, pulse stays one clock.
    cnt = 0;
    for (int i = 0; i < 2 * HT; i++) begin
      step(1'(i % 2 == 0), 1'b0);
      if (hsync == POL) cnt++;
    end
    check("hsync_low_alt_ce", 32'(cnt), 32'(2 * HS));
    cnt = 0; sof_seen = 0;
    for (int i = 0; i < 2 * HT * VT + 4; i++) begin
      step(1'(i % 2 == 0), 1'b0);
      if (startOfFrame) sof_seen++;
    end
    check("sof_count_alt_ce", 32'(sof_seen), 32'd1);

    // Random pixelCE with rare resets.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 499) == 0));

    // Mid-frame reset at frameCount=5, position (5,3).
    step(1'b1, 1'b1);
    limit = 0;
    while (!(mfc == 5 && mx == 5 && my == 3) && limit < 10 * HT * VT) begin
      step(1'($urandom_range(0, 4) != 0), 1'b0); limit++;
    end
    check("reach_mid_frame", 32'(limit < 10 * HT * VT), 32'd1);
    step(1'b1, 1'b1);
    check("midreset_frameCount", 32'(frameCount), 32'd0);
    check("midreset_sof", 32'(startOfFrame), 32'd0);
    check("midreset_x", 32'(pixelX), 32'd0);

    // frameCount wraps 255 -> 0.
    limit = 0;
    while (!(mfc == 255 && mx == HT - 1 && my == VT - 1) && limit < 257 * HT * VT) begin
      step(1'b1, 1'b0); limit++;
    end
    step(1'b1, 1'b0);
    check("fc_wrap", 32'(frameCount), 32'd0);
    check("fc_wrap_sof", 32'(startOfFrame), 32'd1);
    step(1'b0, 1'b0);
    check("sof_clear_ce0", 32'(startOfFrame), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
